// File: rtl/mem_arb_pkg.sv
// Shared widths, starvation default and owner-state encoding
// for the data-memory arbiter.
package mem_arb_pkg;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int CNT_W = 3;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    OWN_IDLE  = 2'd0,
    OWN_PIPE  = 2'd1,
    OWN_LOAD  = 2'd2,
    OWN_FORCE = 2'd3
  } owner_e;
endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive loader cycles that were denied.
// Clear has priority over increment.
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int MAX = STARVE_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             sat_o
);
  localparam logic [CNT_W-1:0] MaxC = CNT_W'(MAX);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MaxC)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = (cnt_q == MaxC);
endmodule

// File: rtl/data_mem_arbiter.sv
// Single-port data memory shared by the MEM stage and a loader;
// the pipeline wins unless the loader has waited STARVE_MAX cycles.
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p_rd,
  input  logic              p_wr,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic [DATA_W-1:0] p_rdata,
  output logic              p_stall,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic [DATA_W-1:0] l_rdata,
  output logic              l_rvalid,
  output logic              m_rd,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);
  logic             p_req;
  logic             sat;
  logic             l_own;
  logic             p_own;
  logic [CNT_W-1:0] starve_cnt;

  owner_e            state_q, state_d;
  logic              ld_rd_q, ld_rd_d;
  logic [DATA_W-1:0] l_rdata_q, l_rdata_d;

  assign p_req = p_rd | p_wr;
  // Ownership is gated by rst_n so nothing reaches memory in reset.
  assign l_own = rst_n & l_req & (~p_req | sat);
  assign p_own = rst_n & p_req & ~l_own;

  arb_starve_ctr #(
    .MAX(STARVE_MAX)
  ) u_ctr (
    .clk  (clk),
    .rst_n(rst_n),
    .inc_i(l_req & ~l_own),
    .clr_i(~l_req | l_own),
    .cnt_o(starve_cnt),
    .sat_o(sat)
  );

  always_comb begin
    m_rd    = 1'b0;
    m_wr    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    state_d = OWN_IDLE;
    unique case (1'b1)
      l_own: begin
        m_rd    = ~l_we;
        m_wr    = l_we;
        m_addr  = l_addr;
        m_wdata = l_wdata;
        state_d = p_req ? OWN_FORCE : OWN_LOAD;
      end
      p_own: begin
        m_rd    = p_rd;
        m_wr    = p_wr;
        m_addr  = p_addr;
        m_wdata = p_wdata;
        state_d = OWN_PIPE;
      end
      default: ;
    endcase
  end

  assign p_rdata = (p_own & p_rd) ? m_rdata : '0;
  assign p_stall = l_own & p_req;
  assign l_gnt   = l_own;

  assign ld_rd_d   = l_own & ~l_we;
  assign l_rdata_d = ld_rd_d ? m_rdata : l_rdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= OWN_IDLE;
      ld_rd_q   <= 1'b0;
      l_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      ld_rd_q   <= ld_rd_d;
      l_rdata_q <= l_rdata_d;
    end
  end

  assign l_rdata  = l_rdata_q;
  assign l_rvalid = ld_rd_q &
                    ((state_q == OWN_LOAD) | (state_q == OWN_FORCE));
endmodule
